my_ifetch: RTL and testbench
============================

# my_ifetch

Instruction fetch sequencer that reads the current PC from `my_pc`, issues a read to instruction memory, and presents the fetched word to decode with a valid/ready handshake. It drives `my_pc` (`ena`, `data_in`) to advance sequentially by 4 or to load a branch or jump target. It also tracks one outstanding memory read, discards stale responses after a redirect, and flags misaligned PCs.

## Interface
Parameters:
- RESET_CNT, 32'd0, reset value of `fetch_cnt`.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- pc_in  in  32  current PC, wired from `my_pc.data_out`.
- pc_ena  out  1  load strobe to `my_pc.ena`; one-cycle pulse.
- pc_next  out  32  value to `my_pc.data_in`.
- redirect  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  memory read request; one-cycle pulse.
- imem_addr  out  32  read address; held until next request.
- imem_rvalid  in  1  read data valid; one pulse per request, at least 1 cycle after `imem_req`.
- imem_rdata  in  32  read data.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts.
- inst_out  out  32  instruction word.
- inst_pc  out  32  address of `inst_out`.
- fault  out  1  sticky misaligned-PC flag.
- fetch_cnt  out  32  count of instructions accepted by decode.

## Operation
- All outputs are registered.
- Reset (`rst`=0 at posedge) sets:
  - state IDLE;
  - `pc_ena`, `imem_req`, `inst_valid`, `fault` = 0;
  - `pc_next`, `imem_addr`, `inst_out`, `inst_pc` = 0;
  - `fetch_cnt` = RESET_CNT.
- Reset mid-operation abandons any outstanding read. A late `imem_rvalid` arriving in IDLE is ignored.
- `pc_ena` defaults to 0 every cycle. `imem_req` defaults to 0 every cycle.
- States:
  - IDLE:
    - If `pc_in[1:0]` != 0: set `fault`=1 and go to FAULT.
    - Otherwise: `imem_req`=1, `imem_addr`=`pc_in`, go to WAIT.
  - WAIT: on `imem_rvalid`:
    - `inst_out`=`imem_rdata`, `inst_pc`=`imem_addr`, `inst_valid`=1;
    - `pc_ena`=1, `pc_next`=`imem_addr`+4 (mod 2^32; 32'hFFFFFFFC wraps to 0);
    - go to HOLD.
  - HOLD: on `inst_valid`&&`inst_ready`:
    - increment `fetch_cnt` (wraps);
    - `inst_valid`=0;
    - issue the next request from `pc_in` exactly as IDLE does, including the misalignment check;
    - go to WAIT (or FAULT).
  - DRAIN: on `imem_rvalid`, discard data and go to IDLE.
  - FAULT: hold; no requests. `fault` stays 1.
- Redirect (highest priority, any state):
  - `pc_ena`=1, `pc_next`=`redirect_pc`, `inst_valid`=0, `fault`=0.
  - Next state: DRAIN if in WAIT with no `imem_rvalid` this cycle; stays DRAIN if already in DRAIN without `imem_rvalid`; IDLE otherwise.
- Simultaneous events:
  - Redirect with `imem_rvalid` in WAIT: data discarded, no sequential `pc_ena`, go to IDLE.
  - Redirect with handshake in HOLD: the instruction counts as accepted (`fetch_cnt` increments), but no new request is issued.
- `inst_out`/`inst_pc` hold stable while `inst_valid`=1 and not accepted.

## Timing
- `my_pc` loads on negedge. A `pc_ena` pulse registered at posedge N is reflected in `pc_in` before posedge N+1, so IDLE/HOLD may sample `pc_in` the cycle after any `pc_ena`.
- First request: `imem_req`=1 after the first posedge with `rst`=1; `imem_addr`=0.
- Memory latency L≥1: `inst_valid` rises 1 cycle after `imem_rvalid`, i.e. L+1 cycles after `imem_req`.
- Steady state with `inst_ready`=1: one instruction every L+2 cycles.
- Redirect to new request:
  - 2 cycles if no read is outstanding;
  - 2 cycles after the discarded `imem_rvalid` if one is outstanding.
- At most one outstanding read at any time.

## Test plan
- Reset, then L=1 memory returning 32'h0000_0013 at every address, `inst_ready`=1:
  - `imem_addr` sequence 0, 4, 8, with `imem_req` every 3 cycles;
  - `inst_pc` 0, 4, 8;
  - `fetch_cnt` reaches 3 after the third acceptance.
- `inst_ready`=0 for 5 cycles while `inst_valid`=1:
  - `inst_out`/`inst_pc` stable;
  - no `imem_req`;
  - single `pc_ena` pulse;
  - acceptance on cycle 6 issues the next request.
- Redirect to 32'h100 while in WAIT with L=4:
  - the response arriving later is discarded, `inst_valid` stays 0;
  - the next `imem_addr` is 32'h100, and 32'h100's instruction is delivered.
- Redirect coincident with `imem_rvalid`:
  - no `inst_valid`;
  - `pc_next`=`redirect_pc`;
  - a request to the target follows 2 cycles later.
- Redirect to 32'h102:
  - `fault`=1, no `imem_req` for 10 cycles;
  - a redirect to 32'h200 clears `fault` and fetches 32'h200.
- Redirect to 32'hFFFF_FFFC:
  - `pc_next` after that fetch = 0;
  - next `imem_addr` = 0.
- Reset asserted during WAIT with a response pending 2 cycles later:
  - outputs return to reset values;
  - the stale `imem_rvalid` is ignored;
  - the first post-reset request goes to address 0.

Source files
------------

// File: rtl/my_ifetch.sv
// Instruction fetch sequencer: drives my_pc, issues one outstanding imem read,
// and hands fetched words to decode over a valid/ready handshake.
//
// state | meaning
// IDLE  | sample pc_in and issue a read, or flag a misaligned PC
// WAIT  | read outstanding, waiting for imem_rvalid
// HOLD  | instruction presented to decode, waiting for acceptance
// DRAIN | discarding the response of a read abandoned by a redirect
// FAULT | misaligned PC seen; parked until a redirect
module my_ifetch #(
  parameter logic [31:0] RESET_CNT = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0] state;
  logic       misaligned;
  logic       accept;

  assign misaligned = |pc_in[1:0];
  assign accept     = (state == S_HOLD) && inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc_ena     <= 1'b0;
      pc_next    <= 32'd0;
      imem_req   <= 1'b0;
      imem_addr  <= 32'd0;
      inst_valid <= 1'b0;
      inst_out   <= 32'd0;
      inst_pc    <= 32'd0;
      fault      <= 1'b0;
      fetch_cnt  <= RESET_CNT;
    end else begin
      pc_ena   <= 1'b0;
      imem_req <= 1'b0;
      // An accepted instruction counts even when a redirect lands in the same cycle.
      if (accept)
        fetch_cnt <= fetch_cnt + 32'd1;

      if (redirect) begin
        pc_ena     <= 1'b1;
        pc_next    <= redirect_pc;
        inst_valid <= 1'b0;
        fault      <= 1'b0;
        if ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid)
          state <= S_DRAIN;
        else
          state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_HOLD: begin
            if (accept)
              inst_valid <= 1'b0;
            if (state == S_IDLE || accept) begin
              if (misaligned) begin
                fault <= 1'b1;
                state <= S_FAULT;
              end else begin
                imem_req  <= 1'b1;
                imem_addr <= pc_in;
                state     <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              inst_out   <= imem_rdata;
              inst_pc    <= imem_addr;
              inst_valid <= 1'b1;
              pc_ena     <= 1'b1;
              pc_next    <= imem_addr + 32'd4;
              state      <= S_HOLD;
            end
          end
          S_DRAIN: begin
            if (imem_rvalid)
              state <= S_IDLE;
          end
          S_FAULT: state <= S_FAULT;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_my_ifetch.sv
// Directed bench for my_ifetch: models my_pc (load on ena) and a fixed-latency
// instruction memory, and checks the fetch sequence against hand-computed values.
module tb_my_ifetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fetch_cnt;

  int checks;
  int failures;
  int req_cnt;
  int ena_cnt;
  int s_req;
  int s_ena;
  int lat;
  int mcnt;
  logic [31:0] maddr;
  bit  addr_data;

  my_ifetch #(.RESET_CNT(32'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_ena      (pc_ena),
    .pc_next     (pc_next),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .fault       (fault),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (addr_data) return {a[23:0], 8'h13};
    return 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then update the my_pc and memory models.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) pc_in = 32'd0;
    else if (pc_ena) pc_in = pc_next;
    if (imem_req) req_cnt++;
    if (pc_ena) ena_cnt++;
    imem_rvalid = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(maddr);
      end
    end
    if (imem_req) begin
      mcnt  = lat;
      maddr = imem_addr;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc_ena"},     32'(pc_ena),     32'd0);
    chk({tag, "_imem_req"},   32'(imem_req),   32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_fault"},      32'(fault),      32'd0);
    chk({tag, "_pc_next"},    pc_next,         32'd0);
    chk({tag, "_imem_addr"},  imem_addr,       32'd0);
    chk({tag, "_inst_out"},   inst_out,        32'd0);
    chk({tag, "_inst_pc"},    inst_pc,         32'd0);
    chk({tag, "_fetch_cnt"},  fetch_cnt,       32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; req_cnt = 0; ena_cnt = 0;
    lat = 1; mcnt = 0; maddr = 32'd0; addr_data = 1'b0;
    rst = 1'b0; pc_in = 32'd0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b1;

    tick(); tick();
    check_reset("reset");

    // Sequential fetch, L=1: request every 3 cycles.
    rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("seq_req",  32'(imem_req), 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      tick();
      chk("seq_gap", 32'(imem_req), 32'd0);
      tick();
      chk("seq_valid",   32'(inst_valid), 32'd1);
      chk("seq_inst_pc", inst_pc, 32'(4 * k));
      chk("seq_inst",    inst_out, 32'h0000_0013);
      chk("seq_pc_next", pc_next, 32'(4 * k + 4));
      tick();
      chk("seq_cnt", fetch_cnt, 32'(k + 1));
    end

    // Decode stalls for 5 cycles on the word at 12.
    inst_ready = 1'b0;
    s_req = req_cnt; s_ena = ena_cnt;
    tick(); tick();
    chk("stall_valid", 32'(inst_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_hold_valid", 32'(inst_valid), 32'd1);
      chk("stall_hold_pc",    inst_pc, 32'd12);
      chk("stall_hold_inst",  inst_out, 32'h0000_0013);
    end
    chk("stall_no_req",  32'(req_cnt - s_req), 32'd0);
    chk("stall_one_ena", 32'(ena_cnt - s_ena), 32'd1);
    inst_ready = 1'b1;
    lat = 4;
    tick();
    chk("stall_accept_req",  32'(imem_req), 32'd1);
    chk("stall_accept_addr", imem_addr, 32'd16);
    chk("stall_accept_cnt",  fetch_cnt, 32'd4);

    // Redirect to 0x100 during WAIT, L=4: stale response drained.
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("rdw_pc_ena",  32'(pc_ena), 32'd1);
    chk("rdw_pc_next", pc_next, 32'h100);
    s_req = req_cnt;
    tick(); tick(); tick();
    chk("rdw_drain_no_req", 32'(req_cnt - s_req), 32'd0);
    chk("rdw_drain_valid",  32'(inst_valid), 32'd0);
    tick();
    chk("rdw_req",  32'(imem_req), 32'd1);
    chk("rdw_addr", imem_addr, 32'h100);
    addr_data = 1'b1;
    tick(); tick(); tick(); tick();
    chk("rdw_wait_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("rdw_valid",   32'(inst_valid), 32'd1);
    chk("rdw_inst",    inst_out, 32'h0001_0013);
    chk("rdw_inst_pc", inst_pc, 32'h100);
    lat = 1;
    tick();
    chk("rdw_cnt",       fetch_cnt, 32'd5);
    chk("rdw_next_addr", imem_addr, 32'h104);

    // Redirect coincident with imem_rvalid.
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("rdv_valid",   32'(inst_valid), 32'd0);
    chk("rdv_pc_ena",  32'(pc_ena), 32'd1);
    chk("rdv_pc_next", pc_next, 32'h40);
    chk("rdv_no_req",  32'(imem_req), 32'd0);
    tick();
    chk("rdv_req",  32'(imem_req), 32'd1);
    chk("rdv_addr", imem_addr, 32'h40);
    tick(); tick();
    chk("rdv_inst_pc", inst_pc, 32'h40);
    chk("rdv_inst",    inst_out, 32'h0000_4013);
    tick();
    chk("rdv_cnt", fetch_cnt, 32'd6);

    // Misaligned redirect target faults until redirected again.
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    chk("mis_pc_next", pc_next, 32'h102);
    tick(); tick();
    chk("mis_fault", 32'(fault), 32'd1);
    s_req = req_cnt;
    repeat (10) tick();
    chk("mis_no_req",     32'(req_cnt - s_req), 32'd0);
    chk("mis_fault_hold", 32'(fault), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("mis_clear", 32'(fault), 32'd0);
    tick();
    chk("mis_req",  32'(imem_req), 32'd1);
    chk("mis_addr", imem_addr, 32'h200);
    tick(); tick();
    chk("mis_inst_pc", inst_pc, 32'h200);
    chk("mis_inst",    inst_out, 32'h0002_0013);
    tick();
    chk("mis_cnt", fetch_cnt, 32'd7);

    // Top-of-memory target: next PC wraps to 0.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_ena",  32'(pc_ena), 32'd1);
    chk("wrap_pc_next", pc_next, 32'd0);
    lat = 2;
    tick();
    chk("wrap_req",  32'(imem_req), 32'd1);
    chk("wrap_next", imem_addr, 32'd0);
    chk("wrap_cnt",  fetch_cnt, 32'd8);

    // Reset during WAIT; the stale response lands in IDLE.
    rst = 1'b0;
    tick(); tick();
    check_reset("midreset");
    rst = 1'b1;
    lat = 1;
    tick();
    chk("post_req",   32'(imem_req), 32'd1);
    chk("post_addr",  imem_addr, 32'd0);
    chk("post_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("post_stale_ignored", 32'(inst_valid), 32'd0);
    tick();
    chk("post_valid_rise", 32'(inst_valid), 32'd1);
    chk("post_inst_pc",    inst_pc, 32'd0);
    chk("post_cnt",        fetch_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
